// File: rtl/wb_port_arbiter_if.sv
// Bus bundle for wb_port_arbiter: pipeline and MD producer inputs, hazard query,
// and the registered register-file write port.
interface wb_port_arbiter_if #(
    parameter int PTR_W = 2
);
    logic             pipe_en;
    logic [4:0]       pipe_a3;
    logic [31:0]      pipe_wd;
    logic [31:0]      pipe_pc8;

    logic             md_valid;
    logic             md_ready;
    logic [4:0]       md_a3;
    logic [31:0]      md_wd;
    logic [31:0]      md_pc8;

    logic [4:0]       q_addr;
    logic             q_hit;

    logic             rf_en;
    logic [4:0]       rf_a3;
    logic [31:0]      rf_wd;
    logic [31:0]      rf_pc8;

    logic [PTR_W:0]   fifo_cnt;

    modport slave (
        input  pipe_en, pipe_a3, pipe_wd, pipe_pc8,
        input  md_valid, md_a3, md_wd, md_pc8,
        input  q_addr,
        output md_ready, q_hit,
        output rf_en, rf_a3, rf_wd, rf_pc8,
        output fifo_cnt
    );

    modport master (
        output pipe_en, pipe_a3, pipe_wd, pipe_pc8,
        output md_valid, md_a3, md_wd, md_pc8,
        output q_addr,
        input  md_ready, q_hit,
        input  rf_en, rf_a3, rf_wd, rf_pc8,
        input  fifo_cnt
    );
endinterface

// File: rtl/wb_port_arbiter.sv
// Write-back port arbiter: pipeline W stage always wins, MD results queue in a FIFO
// and drain into idle cycles. Optional write trace under macro WB_TRACE_EN.
module wb_port_arbiter #(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input logic              clk,
    input logic              reset,
    wb_port_arbiter_if.slave bus
);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

    logic [DEPTH-1:0] ent_valid;
    logic [4:0]       ent_a3  [DEPTH];
    logic [31:0]      ent_wd  [DEPTH];
    logic [31:0]      ent_pc8 [DEPTH];

    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W:0]   count;

    logic             pipe_eff;
    logic             full;
    logic             push;
    logic             pop;
    logic             hit;

    logic             next_en;
    logic [4:0]       next_a3;
    logic [31:0]      next_wd;
    logic [31:0]      next_pc8;

    assign pipe_eff     = bus.pipe_en && (bus.pipe_a3 != 5'd0);
    assign full         = (count == FULL_CNT);
    assign bus.md_ready = !full;
    assign push         = bus.md_valid && !full && (bus.md_a3 != 5'd0);
    assign bus.fifo_cnt = count;

    // Head is consumed whenever the pipeline leaves the port free; squashed heads write nothing.
    always_comb begin
        next_en  = 1'b0;
        next_a3  = bus.rf_a3;
        next_wd  = bus.rf_wd;
        next_pc8 = bus.rf_pc8;
        pop      = 1'b0;
        if (pipe_eff) begin
            next_en  = 1'b1;
            next_a3  = bus.pipe_a3;
            next_wd  = bus.pipe_wd;
            next_pc8 = bus.pipe_pc8;
        end else if (count != '0) begin
            pop = 1'b1;
            if (ent_valid[rd_ptr]) begin
                next_en  = 1'b1;
                next_a3  = ent_a3[rd_ptr];
                next_wd  = ent_wd[rd_ptr];
                next_pc8 = ent_pc8[rd_ptr];
            end
        end
    end

    always_comb begin
        hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (ent_valid[i] && (ent_a3[i] == bus.q_addr)) begin
                hit = 1'b1;
            end
        end
        bus.q_hit = hit && (bus.q_addr != 5'd0);
    end

    // The push is applied after the squash so an entry stored this cycle stays valid.
    always_ff @(posedge clk) begin
        if (!reset) begin
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
            ent_valid <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (pipe_eff && (ent_a3[i] == bus.pipe_a3)) begin
                    ent_valid[i] <= 1'b0;
                end
            end
            if (pop) begin
                ent_valid[rd_ptr] <= 1'b0;
                rd_ptr            <= rd_ptr + 1'b1;
            end
            if (push) begin
                ent_valid[wr_ptr] <= 1'b1;
                wr_ptr            <= wr_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            ent_a3[wr_ptr]  <= bus.md_a3;
            ent_wd[wr_ptr]  <= bus.md_wd;
            ent_pc8[wr_ptr] <= bus.md_pc8;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            bus.rf_en  <= 1'b0;
            bus.rf_a3  <= 5'd0;
            bus.rf_wd  <= 32'd0;
            bus.rf_pc8 <= 32'd0;
        end else begin
            bus.rf_en  <= next_en;
            bus.rf_a3  <= next_a3;
            bus.rf_wd  <= next_wd;
            bus.rf_pc8 <= next_pc8;
        end
    end

`ifdef WB_TRACE_EN
    always @(posedge clk) begin
        if (reset && next_en) begin
            $display("%d@%h: $%d <= %h", $time, next_pc8 - 32'd8, next_a3, next_wd);
        end
    end
`else
`endif

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Randomized and directed bench for wb_port_arbiter against a queue-based
// reference model of the write-port rules.
module tb_wb_port_arbiter;
    localparam int DEPTH = 4;
    localparam int PTR_W = 2;

    typedef struct {
        logic [4:0]  a3;
        logic [31:0] wd;
        logic [31:0] pc8;
        bit          valid;
    } entry_t;

    logic clk;
    logic reset;

    wb_port_arbiter_if #(.PTR_W(PTR_W)) bus ();

    wb_port_arbiter #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    entry_t      modelQ[$];
    logic        expEn;
    logic [4:0]  expA3;
    logic [31:0] expWd;
    logic [31:0] expPc8;
    int          checkCount;
    int          passCount;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checkCount++;
        if (got !== exp) begin
            $display("[TB] FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end else begin
            passCount++;
        end
    endtask

    function automatic logic modelHit(input logic [4:0] qa);
        logic h;
        h = 1'b0;
        foreach (modelQ[i]) begin
            if (modelQ[i].valid && modelQ[i].a3 == qa && qa != 5'd0) h = 1'b1;
        end
        return h;
    endfunction

    // One cycle: drive at negedge, check combinational outputs, step model, check registers.
    task automatic applyStimulus(input logic rst, input logic pe, input logic [4:0] pa3,
                                 input logic [31:0] pwd, input logic [31:0] ppc8,
                                 input logic mv, input logic [4:0] ma3,
                                 input logic [31:0] mwd, input logic [31:0] mpc8,
                                 input logic [4:0] qa);
        bit     pipeEff;
        bit     accept;
        entry_t e;
        @(negedge clk);
        reset        = rst;
        bus.pipe_en  = pe;
        bus.pipe_a3  = pa3;
        bus.pipe_wd  = pwd;
        bus.pipe_pc8 = ppc8;
        bus.md_valid = mv;
        bus.md_a3    = ma3;
        bus.md_wd    = mwd;
        bus.md_pc8   = mpc8;
        bus.q_addr   = qa;
        #1;
        checkOutput("md_ready", {31'd0, bus.md_ready}, {31'd0, modelQ.size() != DEPTH});
        checkOutput("fifo_cnt", {29'd0, bus.fifo_cnt}, modelQ.size());
        checkOutput("q_hit", {31'd0, bus.q_hit}, {31'd0, modelHit(qa)});

        if (!rst) begin
            modelQ.delete();
            expEn  = 1'b0;
            expA3  = 5'd0;
            expWd  = 32'd0;
            expPc8 = 32'd0;
        end else begin
            pipeEff = pe && (pa3 != 5'd0);
            accept  = mv && (modelQ.size() != DEPTH) && (ma3 != 5'd0);
            expEn   = 1'b0;
            if (pipeEff) begin
                expEn  = 1'b1;
                expA3  = pa3;
                expWd  = pwd;
                expPc8 = ppc8;
                foreach (modelQ[i]) begin
                    if (modelQ[i].a3 == pa3) modelQ[i].valid = 1'b0;
                end
            end else if (modelQ.size() != 0) begin
                e = modelQ.pop_front();
                if (e.valid) begin
                    expEn  = 1'b1;
                    expA3  = e.a3;
                    expWd  = e.wd;
                    expPc8 = e.pc8;
                end
            end
            if (accept) begin
                e.a3    = ma3;
                e.wd    = mwd;
                e.pc8   = mpc8;
                e.valid = 1'b1;
                modelQ.push_back(e);
            end
        end

        @(posedge clk);
        #1;
        checkOutput("rf_en", {31'd0, bus.rf_en}, {31'd0, expEn});
        checkOutput("rf_a3", {27'd0, bus.rf_a3}, {27'd0, expA3});
        checkOutput("rf_wd", bus.rf_wd, expWd);
        checkOutput("rf_pc8", bus.rf_pc8, expPc8);
    endtask

    task automatic idleCycle(input logic [4:0] qa);
        applyStimulus(1'b1, 1'b0, 5'd0, 32'd0, 32'd0, 1'b0, 5'd0, 32'd0, 32'd0, qa);
    endtask

    initial begin
        checkCount = 0;
        passCount  = 0;
        expEn = 1'b0; expA3 = 5'd0; expWd = 32'd0; expPc8 = 32'd0;
        reset = 1'b0;
        bus.pipe_en = 1'b0; bus.pipe_a3 = 5'd0; bus.pipe_wd = 32'd0; bus.pipe_pc8 = 32'd0;
        bus.md_valid = 1'b0; bus.md_a3 = 5'd0; bus.md_wd = 32'd0; bus.md_pc8 = 32'd0;
        bus.q_addr = 5'd0;

        $display("[TB] reset then idle");
        @(posedge clk);
        applyStimulus(1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 1'b0, 5'd0, 32'd0, 32'd0, 5'd0);
        idleCycle(5'd0);

        $display("[TB] pipeline only");
        applyStimulus(1'b1, 1'b1, 5'd5, 32'h1234, 32'h3008, 1'b0, 5'd0, 32'd0, 32'd0, 5'd0);
        applyStimulus(1'b1, 1'b1, 5'd0, 32'h5555, 32'h300c, 1'b0, 5'd0, 32'd0, 32'd0, 5'd0);

        $display("[TB] contention");
        applyStimulus(1'b1, 1'b1, 5'd9, 32'h90, 32'h4008, 1'b1, 5'd8, 32'hAA, 32'h5008, 5'd8);
        applyStimulus(1'b1, 1'b1, 5'd9, 32'h91, 32'h400c, 1'b0, 5'd0, 32'd0, 32'd0, 5'd8);
        applyStimulus(1'b1, 1'b1, 5'd9, 32'h92, 32'h4010, 1'b0, 5'd0, 32'd0, 32'd0, 5'd8);
        idleCycle(5'd8);
        idleCycle(5'd8);

        $display("[TB] full and wrap");
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, 1'b1, 5'd1, 32'h100 + i, 32'h6000 + 4 * i,
                          1'b1, 5'(11 + i), 32'hB00 + i, 32'h7000 + 4 * i, 5'(11 + i));
        end
        for (int i = 0; i < 4; i++) idleCycle(5'd14);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 1'b1, 5'd2, 32'h200 + i, 32'h8000 + 4 * i,
                          1'b1, 5'(20 + i), 32'hC00 + i, 32'h9000 + 4 * i, 5'(20 + i));
        end
        for (int i = 0; i < 4; i++) idleCycle(5'd20);

        $display("[TB] WAW squash");
        applyStimulus(1'b1, 1'b1, 5'd1, 32'h11, 32'hA008, 1'b1, 5'd10, 32'h1, 32'hB008, 5'd10);
        applyStimulus(1'b1, 1'b1, 5'd10, 32'h2, 32'hA00c, 1'b0, 5'd0, 32'd0, 32'd0, 5'd10);
        idleCycle(5'd10);
        idleCycle(5'd10);

        $display("[TB] reset mid-operation");
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 1'b1, 5'd3, 32'h300 + i, 32'hC000 + 4 * i,
                          1'b1, 5'(24 + i), 32'hD00 + i, 32'hE000 + 4 * i, 5'd24);
        end
        applyStimulus(1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 1'b0, 5'd0, 32'd0, 32'd0, 5'd24);
        for (int i = 0; i < 4; i++) idleCycle(5'd24);

        $display("[TB] randomized traffic");
        for (int n = 0; n < 1500; n++) begin
            applyStimulus(($urandom_range(0, 63) != 0),
                          ($urandom_range(0, 99) < 45),
                          5'($urandom_range(0, 7)), $urandom, $urandom,
                          ($urandom_range(0, 99) < 50),
                          5'($urandom_range(0, 7)), $urandom, $urandom,
                          5'($urandom_range(0, 7)));
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end
endmodule
